// File: rtl/score_board_pkg.sv
// Shared types, digit indices, 7-segment patterns and BCD helper for score_board.
package score_board_pkg;

  typedef enum logic {PLAY = 1'b0, GAME_OVER = 1'b1} state_e;

  localparam logic [1:0] DIG_P2_UNITS = 2'd0;
  localparam logic [1:0] DIG_P2_TENS  = 2'd1;
  localparam logic [1:0] DIG_P1_UNITS = 2'd2;
  localparam logic [1:0] DIG_P1_TENS  = 2'd3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [7:0] to_bcd(input int value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'((value / 10) % 10);
    units = 4'(value % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; blank or non-decimal input darkens the digit.
module seg7_decode
  import score_board_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_board.sv
// Two-player BCD scoreboard with win detection and 4-digit multiplexed 7-segment drive.
// Optional winner blinking in GAME_OVER is built when BLINK_WINNER_EN is defined.
module score_board
  import score_board_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int REFRESH_BITS = 16,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] lose1,
  input  logic [1:0] lose2,
  input  logic       new_game,
  output logic [3:0] seg_select,
  output logic [6:0] seg,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [7:0] WIN_BCD = to_bcd(WIN_SCORE);
  localparam int         CW      = REFRESH_BITS + 2;

  // BCD ordering matches numeric ordering, so saturation is a plain compare
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] s, input logic [1:0] d);
    logic [3:0] u;
    logic [3:0] t;
    logic [7:0] r;
    u = s[3:0] + {2'b00, d};
    t = s[7:4];
    if (u > 4'd9) begin
      u = u - 4'd10;
      t = t + 4'd1;
    end
    r = {t, u};
    return (r > WIN_BCD) ? WIN_BCD : r;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    p1_q, p1_d;
  logic [7:0]    p2_q, p2_d;
  logic [1:0]    winner_q, winner_d;
  logic [1:0]    prev1_q, prev2_q;
  logic [1:0]    delta1, delta2;
  logic [CW-1:0] cnt_q;
  logic [3:0]    seg_select_q, seg_select_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    digit;
  logic [3:0]    nib;
  logic          blank;
  logic          blink_on;

  always_comb begin
    delta1   = lose1 - prev1_q;
    delta2   = lose2 - prev2_q;
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    if (new_game) begin
      state_d  = PLAY;
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      winner_d = 2'b00;
    end else if (state_q == PLAY) begin
      p1_d = bcd_add_sat(p1_q, delta2);
      p2_d = bcd_add_sat(p2_q, delta1);
      if (p1_d == WIN_BCD || p2_d == WIN_BCD) begin
        state_d  = GAME_OVER;
        winner_d = {p2_d == WIN_BCD, p1_d == WIN_BCD};
      end
    end
  end

`ifdef BLINK_WINNER_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + BLINK_BITS'(1);
  end

  assign blink_on = (state_q == GAME_OVER) && blink_q[BLINK_BITS-1];
`else
  // Never blinks; the expression only keeps BLINK_BITS referenced
  assign blink_on = (BLINK_BITS < 0);
`endif

  always_comb begin
    digit = cnt_q[REFRESH_BITS+1:REFRESH_BITS];
    nib   = 4'd0;
    blank = 1'b1;
    case (digit)
      DIG_P2_UNITS: begin nib = p2_q[3:0]; blank = blink_on & winner_q[1]; end
      DIG_P2_TENS:  begin nib = p2_q[7:4]; blank = (p2_q[7:4] == 4'd0) | (blink_on & winner_q[1]); end
      DIG_P1_UNITS: begin nib = p1_q[3:0]; blank = blink_on & winner_q[0]; end
      DIG_P1_TENS:  begin nib = p1_q[7:4]; blank = (p1_q[7:4] == 4'd0) | (blink_on & winner_q[0]); end
      default:      begin nib = 4'd0;      blank = 1'b1; end
    endcase
    seg_select_d = ~(4'b0001 << digit);
  end

  seg7_decode u_dec (
    .bcd_i   (nib),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PLAY;
      p1_q         <= 8'h00;
      p2_q         <= 8'h00;
      winner_q     <= 2'b00;
      prev1_q      <= 2'b00;
      prev2_q      <= 2'b00;
      cnt_q        <= '0;
      seg_select_q <= 4'b1111;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      prev1_q      <= lose1;
      prev2_q      <= lose2;
      cnt_q        <= cnt_q + CW'(1);
      seg_select_q <= seg_select_d;
      seg_q        <= seg_d;
    end
  end

  assign seg_select = seg_select_q;
  assign seg        = seg_q;
  assign game_over  = (state_q == GAME_OVER);
  assign winner     = winner_q;

endmodule

// File: tb/tb_score_board.sv
// Directed bench for score_board with a short refresh period; scores are read back from the display.
module tb_score_board;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lose1, lose2;
  logic       new_game;
  logic [3:0] seg_select;
  logic [6:0] seg;
  logic       game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;
  logic [1:0] l1 = 2'b00;
  logic [1:0] l2 = 2'b00;

  score_board #(.WIN_SCORE(11), .REFRESH_BITS(2), .BLINK_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .lose1      (lose1),
    .lose2      (lose2),
    .new_game   (new_game),
    .seg_select (seg_select),
    .seg        (seg),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // {digit3, digit2, digit1, digit0} for P1 score p1 and P2 score p2
  function automatic logic [27:0] exp_disp(input int p1, input int p2);
    logic [6:0] t1, t2;
    t1 = (p1 < 10) ? 7'b1111111 : seg_of(p1 / 10);
    t2 = (p2 < 10) ? 7'b1111111 : seg_of(p2 / 10);
    return {t1, seg_of(p1 % 10), t2, seg_of(p2 % 10)};
  endfunction

  task automatic read_display(output logic [27:0] obs);
    logic [3:0] want;
    int n;
    obs = '1;
    for (int d = 0; d < 4; d++) begin
      want = ~(4'b0001 << d);
      n = 0;
      while (seg_select !== want && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (n >= 64) begin
        checks++; failures++;
        $display("FAIL display_timeout digit=%0d seg_select=%b required=%b", d, seg_select, want);
      end
      obs[d*7 +: 7] = seg;
    end
  endtask

  task automatic step(input logic [1:0] d1, input logic [1:0] d2, input logic ng);
    @(posedge clk); #1;
    l1 = l1 + d1;
    l2 = l2 + d2;
    lose1 = l1;
    lose2 = l2;
    new_game = ng;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    logic [3:0] exp_sel [3];
    logic [27:0] obs;
    int n;
    exp_sel = '{4'b1101, 4'b1011, 4'b0111};
    repeat (3) @(negedge clk);
    checks++; if (seg_select !== 4'b1111) begin failures++; $display("FAIL rst_seg_select got=%b exp=1111", seg_select); end
    checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL rst_seg got=%b exp=1111111", seg); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL rst_game_over got=%b exp=0", game_over); end
    checks++; if (winner !== 2'b00) begin failures++; $display("FAIL rst_winner got=%b exp=00", winner); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (seg_select !== 4'b1110) begin failures++; $display("FAIL first_digit_sel got=%b exp=1110", seg_select); end
    checks++; if (seg !== 7'b1000000) begin failures++; $display("FAIL first_digit_seg got=%b exp=1000000", seg); end
    for (int i = 0; i < 3; i++) begin
      prev = seg_select;
      n = 0;
      while (seg_select === prev && n < 8) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (seg_select !== exp_sel[i]) begin
        failures++; $display("FAIL scan_order idx=%0d got=%b exp=%b", i, seg_select, exp_sel[i]);
      end
    end
    read_display(obs);
    checks++; if (obs !== exp_disp(0, 0)) begin failures++; $display("FAIL reset_display got=%h exp=%h", obs, exp_disp(0, 0)); end
  endtask

  task automatic test_scoring();
    logic [27:0] obs;
    step(2'd1, 2'd0, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 1)) begin failures++; $display("FAIL score_p2_1 got=%h exp=%h", obs, exp_disp(0, 1)); end
    step(2'd1, 2'd0, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 2)) begin failures++; $display("FAIL score_p2_2 got=%h exp=%h", obs, exp_disp(0, 2)); end
    step(2'd0, 2'd3, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(3, 2)) begin failures++; $display("FAIL score_delta3 got=%h exp=%h", obs, exp_disp(3, 2)); end
  endtask

  task automatic test_bcd_carry();
    logic [27:0] obs;
    step(2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 9; i++) step(2'd1, 2'd0, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 9)) begin failures++; $display("FAIL carry_pre got=%h exp=%h", obs, exp_disp(0, 9)); end
    step(2'd1, 2'd0, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 10)) begin failures++; $display("FAIL carry_10 got=%h exp=%h", obs, exp_disp(0, 10)); end
  endtask

  task automatic test_simultaneous_win();
    logic [27:0] obs;
    step(2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'd3, 2'd3, 1'b0);
    step(2'd1, 2'd1, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(10, 10)) begin failures++; $display("FAIL win_pre got=%h exp=%h", obs, exp_disp(10, 10)); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL win_pre_go got=%b exp=0", game_over); end
    step(2'd1, 2'd1, 1'b0);
    settle();
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL win_go got=%b exp=1", game_over); end
    checks++; if (winner !== 2'b11) begin failures++; $display("FAIL win_both got=%b exp=11", winner); end
    read_display(obs);
    checks++; if (obs !== exp_disp(11, 11)) begin failures++; $display("FAIL win_11 got=%h exp=%h", obs, exp_disp(11, 11)); end
    step(2'd2, 2'd3, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(11, 11)) begin failures++; $display("FAIL frozen got=%h exp=%h", obs, exp_disp(11, 11)); end
  endtask

  task automatic test_new_game();
    logic [27:0] obs;
    step(2'd1, 2'd0, 1'b1);
    settle();
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL ng_go got=%b exp=0", game_over); end
    checks++; if (winner !== 2'b00) begin failures++; $display("FAIL ng_winner got=%b exp=00", winner); end
    read_display(obs);
    checks++; if (obs !== exp_disp(0, 0)) begin failures++; $display("FAIL ng_scores got=%h exp=%h", obs, exp_disp(0, 0)); end
    step(2'd1, 2'd0, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 1)) begin failures++; $display("FAIL ng_no_backlog got=%h exp=%h", obs, exp_disp(0, 1)); end
    // 1 + 9 = 10, then +3 saturates at 11 with P2 the sole winner
    for (int i = 0; i < 3; i++) step(2'd3, 2'd0, 1'b0);
    step(2'd3, 2'd0, 1'b0);
    settle();
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL sat_go got=%b exp=1", game_over); end
    checks++; if (winner !== 2'b10) begin failures++; $display("FAIL sat_winner got=%b exp=10", winner); end
    read_display(obs);
    checks++; if (obs !== exp_disp(0, 11)) begin failures++; $display("FAIL sat_score got=%h exp=%h", obs, exp_disp(0, 11)); end
  endtask

  task automatic test_async_reset();
    logic [27:0] obs;
    step(2'd0, 2'd0, 1'b1);
    step(2'd3, 2'd3, 1'b0);
    step(2'd2, 2'd3, 1'b0);
    step(2'd0, 2'd1, 1'b0);
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(7, 5)) begin failures++; $display("FAIL pre_rst got=%h exp=%h", obs, exp_disp(7, 5)); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (seg_select !== 4'b1111) begin failures++; $display("FAIL async_sel got=%b exp=1111", seg_select); end
    checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL async_seg got=%b exp=1111111", seg); end
    l1 = 2'b00; l2 = 2'b00;
    lose1 = l1; lose2 = l2;
    @(negedge clk);
    rst = 1'b0;
    settle(); read_display(obs);
    checks++; if (obs !== exp_disp(0, 0)) begin failures++; $display("FAIL post_rst got=%h exp=%h", obs, exp_disp(0, 0)); end
  endtask

  initial begin
    rst = 1'b1;
    lose1 = 2'b00;
    lose2 = 2'b00;
    new_game = 1'b0;
    test_reset();
    test_scoring();
    test_bcd_carry();
    test_simultaneous_win();
    test_new_game();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
